classificador_face: RTL and testbench

Downstream consumer of the 3x3 sticker-sample memory filled by the OV7670 capture stage. On `inicia`, it reads the nine stored RGB565 pixels in raster order and classifies each one into one of the six cube colours. It then publishes the packed 27-bit face code with a one-cycle `pronto` pulse. The result feeds the cube-state assembler and the solver link.

---
 rtl/cubo_pkg.sv | 38 +++
 rtl/classificador_pixel.sv | 43 ++++
 rtl/classificador_face.sv | 94 +++++++++
 tb/tb_classificador_face.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cubo_pkg.sv
// Shared definitions for the cube face reader: colour codes, FSM encoding, face geometry.
// Pure declarations; no latency.
// No flow control.
package cubo_pkg;

    localparam int FACE_W  = 27;
    localparam int N_SLOTS = 9;
    localparam int COR_W   = 3;

    typedef enum logic [COR_W-1:0] {
        COR_BRANCO   = 3'd0,
        COR_AMARELO  = 3'd1,
        COR_LARANJA  = 3'd2,
        COR_VERMELHO = 3'd3,
        COR_VERDE    = 3'd4,
        COR_AZUL     = 3'd5
    } cor_t;

    typedef enum logic [2:0] {
        INICIAL    = 3'd0,
        ENDERECA   = 3'd1,
        ESPERA     = 3'd2,
        CLASSIFICA = 3'd3,
        FIM        = 3'd4
    } estado_t;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
    } rgb_t;

    // Bit offset of slot 3*linha+coluna inside the packed face word.
    function automatic logic [4:0] slot_base(input logic [1:0] linha, input logic [1:0] coluna);
        return 5'(linha) * 5'd9 + 5'(coluna) * 5'd3;
    endfunction

endpackage

// File: rtl/classificador_pixel.sv
// RGB565 -> 3-bit cube colour code, first-match priority over the thresholds.
// Combinational, zero latency.
// No flow control; output follows pixel.
module classificador_pixel
    import cubo_pkg::*;
#(
    parameter int T_WHITE = 24,
    parameter int T_HIGH  = 16,
    parameter int T_MID   = 8
) (
    input  logic [15:0]      pixel,
    output logic [COR_W-1:0] cor
);

    localparam logic [4:0] TW = 5'(T_WHITE);
    localparam logic [4:0] TH = 5'(T_HIGH);
    localparam logic [4:0] TM = 5'(T_MID);

    rgb_t c;
    logic g_lsb_unused;

    // Green keeps only its top 5 bits so all channels compare on the same scale.
    assign c.r          = pixel[15:11];
    assign c.g          = pixel[10:6];
    assign c.b          = pixel[4:0];
    assign g_lsb_unused = pixel[5];

    always_comb begin
        cor = COR_AZUL;
        if (c.r >= TW && c.g >= TW && c.b >= TW) begin
            cor = COR_BRANCO;
        end else if (c.r >= TH && c.g >= TH && c.b < TH) begin
            cor = COR_AMARELO;
        end else if (c.r >= TH && c.g >= TM && c.g < TH) begin
            cor = COR_LARANJA;
        end else if (c.r >= TH) begin
            cor = COR_VERMELHO;
        end else if (c.g >= c.b) begin
            cor = COR_VERDE;
        end
    end

endmodule

// File: rtl/classificador_face.sv
// Sweeps the 3x3 sample memory in raster order, classifies each pixel, publishes a 27-bit face.
// 3 cycles per pixel; face/pronto valid 28 cycles after inicia is sampled.
// No backpressure; inicia is ignored while busy.
module classificador_face
    import cubo_pkg::*;
#(
    parameter int T_WHITE = 24,
    parameter int T_HIGH  = 16,
    parameter int T_MID   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inicia,
    input  logic [15:0]       pixel,
    output logic [1:0]        linha_addr,
    output logic [1:0]        coluna_addr,
    output logic [FACE_W-1:0] face,
    output logic              pronto,
    output logic              ocupado
);

    estado_t           estado, prox_estado;
    logic [1:0]        linha, coluna;
    logic [FACE_W-1:0] trabalho, trabalho_prox;
    logic [COR_W-1:0]  cor;
    logic [4:0]        base_bit;
    logic              ultimo;

    classificador_pixel #(
        .T_WHITE (T_WHITE),
        .T_HIGH  (T_HIGH),
        .T_MID   (T_MID)
    ) u_pixel (
        .pixel (pixel),
        .cor   (cor)
    );

    assign ultimo      = (linha == 2'd2) && (coluna == 2'd2);
    assign base_bit    = slot_base(linha, coluna);
    assign linha_addr  = linha;
    assign coluna_addr = coluna;
    assign ocupado     = (estado != INICIAL);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado   = estado;
        trabalho_prox = trabalho;
        case (estado)
            INICIAL:    if (inicia) prox_estado = ENDERECA;
            ENDERECA:   prox_estado = ESPERA;
            ESPERA:     prox_estado = CLASSIFICA;
            CLASSIFICA: begin
                trabalho_prox[base_bit +: COR_W] = cor;
                prox_estado = ultimo ? FIM : ENDERECA;
            end
            FIM:        prox_estado = INICIAL;
            default:    prox_estado = INICIAL;
        endcase
    end

    // face and pronto load on the edge into FIM so both are visible during the FIM cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            linha    <= 2'd0;
            coluna   <= 2'd0;
            trabalho <= '0;
            face     <= '0;
            pronto   <= 1'b0;
        end else begin
            trabalho <= trabalho_prox;
            pronto   <= (estado == CLASSIFICA) && ultimo;
            if (estado == CLASSIFICA) begin
                if (ultimo) begin
                    linha  <= 2'd0;
                    coluna <= 2'd0;
                    face   <= trabalho_prox;
                end else if (coluna == 2'd2) begin
                    coluna <= 2'd0;
                    linha  <= linha + 2'd1;
                end else begin
                    coluna <= coluna + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_classificador_face.sv
// Scoreboard bench for classificador_face: expected faces queued at inicia, popped on pronto.
module tb_classificador_face;
    import cubo_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              inicia = 1'b0;
    logic [15:0]       pixel;
    logic [1:0]        linha_addr, coluna_addr;
    logic [FACE_W-1:0] face;
    logic              pronto, ocupado;

    classificador_face dut (
        .clock       (clock),
        .reset       (reset),
        .inicia      (inicia),
        .pixel       (pixel),
        .linha_addr  (linha_addr),
        .coluna_addr (coluna_addr),
        .face        (face),
        .pronto      (pronto),
        .ocupado     (ocupado)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [0:8];
    int mem_idx;
    always_comb begin
        mem_idx = int'(linha_addr) * 3 + int'(coluna_addr);
        pixel   = (mem_idx < 9) ? mem[mem_idx] : 16'h0000;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [FACE_W-1:0] face;
        int                cyc;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int base     = -1;
    logic [FACE_W-1:0] face_hold = '0;

    localparam logic [FACE_W-1:0] FACE_A = 27'h222C688;
    localparam logic [FACE_W-1:0] FACE_B = 27'o353214430;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] px(input logic [4:0] r, input logic [4:0] g, input logic [4:0] b);
        return {r, g, 1'b0, b};
    endfunction

    task automatic load_a();
        mem[0] = 16'hFFFF; mem[1] = 16'hFFE0; mem[2] = 16'hFA80;
        mem[3] = 16'hF800; mem[4] = 16'h07E0; mem[5] = 16'h001F;
        mem[6] = 16'hFFFF; mem[7] = 16'hFFE0; mem[8] = 16'hFA80;
    endtask

    // Threshold corner pixels: codes 0,3,4,4,1,2,3,5,3 for slots 0..8.
    task automatic load_b();
        mem[0] = px(5'd24, 5'd24, 5'd24);
        mem[1] = px(5'd23, 5'd23, 5'd23);
        mem[2] = px(5'd15, 5'd0,  5'd0);
        mem[3] = px(5'd0,  5'd0,  5'd0);
        mem[4] = px(5'd16, 5'd16, 5'd15);
        mem[5] = px(5'd16, 5'd8,  5'd31);
        mem[6] = px(5'd16, 5'd7,  5'd0);
        mem[7] = px(5'd15, 5'd10, 5'd11);
        mem[8] = px(5'd24, 5'd24, 5'd23);
    endtask

    // Pulse inicia for the current cycle N; pronto expected in cycle N+28.
    task automatic start_run(input logic [FACE_W-1:0] exp_face);
        exp_t e;
        e.face = exp_face;
        e.cyc  = cyc + 28;
        q.push_back(e);
        base   = cyc;
        inicia = 1'b1;
        tick(1);
        inicia = 1'b0;
    endtask

    // Monitor: every pronto must match the oldest queued expectation.
    always @(negedge clock) begin
        if (pronto === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pronto: got pronto=1, expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("face_on_pronto", 32'(face), 32'(e.face));
                check("pronto_cycle", cyc, e.cyc);
            end
        end
    end

    // Sweep tracker: address sequence, ocupado window and face hold, relative to base.
    int k_t, slot_t;
    always @(negedge clock) begin
        if (base >= 0 && reset === 1'b1) begin
            k_t = cyc - base;
            if (k_t >= 1 && k_t <= 27) begin
                slot_t = (k_t - 1) / 3;
                check("linha_addr", 32'(linha_addr), slot_t / 3);
                check("coluna_addr", 32'(coluna_addr), slot_t % 3);
                check("face_hold", 32'(face), 32'(face_hold));
                check("ocupado_busy", 32'(ocupado), 1);
                check("pronto_quiet", 32'(pronto), 0);
            end else if (k_t == 28) begin
                check("linha_after", 32'(linha_addr), 0);
                check("coluna_after", 32'(coluna_addr), 0);
                check("ocupado_fim", 32'(ocupado), 1);
            end else if (k_t == 29) begin
                check("ocupado_fall", 32'(ocupado), 0);
                check("pronto_fall", 32'(pronto), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        load_a();
        tick(3);
        check("rst_face", 32'(face), 0);
        check("rst_pronto", 32'(pronto), 0);
        check("rst_ocupado", 32'(ocupado), 0);
        reset = 1'b1;
        tick(50);
        check("idle_face", 32'(face), 0);
        check("idle_pronto", 32'(pronto), 0);
        check("idle_ocupado", 32'(ocupado), 0);
        check("idle_linha", 32'(linha_addr), 0);
        check("idle_coluna", 32'(coluna_addr), 0);

        // Reference face from the test-plan memory image.
        face_hold = '0;
        start_run(FACE_A);
        tick(39);
        check("run_a_done", q.size(), 0);

        // Threshold corners.
        load_b();
        face_hold = FACE_A;
        start_run(FACE_B);
        tick(39);
        check("run_b_done", q.size(), 0);

        // inicia mid-sweep is ignored.
        load_a();
        face_hold = FACE_B;
        start_run(FACE_A);
        tick(9);
        inicia = 1'b1;
        tick(1);
        inicia = 1'b0;
        tick(30);
        check("ignored_done", q.size(), 0);

        // Back-to-back: inicia held high restarts in cycle 29.
        load_b();
        face_hold = FACE_A;
        start_run(FACE_B);
        inicia = 1'b1;
        tick(28);
        begin
            exp_t e;
            e.face = FACE_B;
            e.cyc  = cyc + 28;
            q.push_back(e);
        end
        tick(1);
        base      = cyc - 1;
        face_hold = FACE_B;
        inicia    = 1'b0;
        tick(40);
        check("b2b_done", q.size(), 0);

        // Reset in the middle of a sweep.
        load_a();
        start_run(FACE_A);
        tick(14);
        reset = 1'b0;
        #1;
        check("midrst_face", 32'(face), 0);
        check("midrst_pronto", 32'(pronto), 0);
        check("midrst_ocupado", 32'(ocupado), 0);
        check("midrst_linha", 32'(linha_addr), 0);
        check("midrst_coluna", 32'(coluna_addr), 0);
        q.delete();
        base      = -1;
        face_hold = '0;
        tick(2);
        reset = 1'b1;
        tick(2);
        start_run(FACE_A);
        tick(39);
        check("after_rst_done", q.size(), 0);
        check("final_face", 32'(face), 32'(FACE_A));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
